// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_pkg
// Purpose  : Shared helpers for the elastic register pipeline: the count-width
//            function, the stage record macro and the parameter guard macro.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef REG_PKG_MACROS
`define REG_PKG_MACROS
// One pipeline stage as a packed record: valid flag plus a W-bit payload.
`define REG_STAGE_T(W) struct packed { logic v; logic [(W)-1:0] d; }
// Elaboration-time guard; LABEL must be a unique g_* block name.
`define REG_PARAM_CHECK(LABEL, COND, MSG) \
  if (!(COND)) begin : LABEL \
    $error(MSG); \
  end
`endif

package reg_pkg;

  // Width needed to hold the values 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipeline_if
// Purpose  : Valid/ready bus of the elastic register pipeline, with master
//            (producer/consumer side) and slave (pipeline side) views.
// Revision : 1.0 - initial release
// ============================================================================

interface reg_pipeline_if
  import reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);

  localparam int c_cnt_w = clog2_cnt(DEPTH);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [c_cnt_w-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Purpose  : One load-enabled pipeline register with its own valid bit.
// Revision : 1.0 - initial release
// ============================================================================

module pipe_stage #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             load,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  typedef `REG_STAGE_T(WIDTH) stage_t;

  stage_t r_stage;

  // Payload is only written by a valid word, so a bubble moving through
  // leaves the previous data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage.v <= 1'b0;
      r_stage.d <= RESET_VALUE;
    end else if (flush) begin
      r_stage.v <= 1'b0;
    end else if (load) begin
      r_stage.v <= up_valid;
      if (up_valid) begin
        r_stage.d <= up_data;
      end
    end
  end

  assign v = r_stage.v;
  assign d = r_stage.d;

endmodule

`default_nettype wire

// File: rtl/reg_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipeline
// Purpose  : Elastic DEPTH-stage register pipeline with valid/ready on both
//            sides, bubble collapsing, synchronous flush and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================

module reg_pipeline
  import reg_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  reg_pipeline_if.slave     bus
);

  localparam int c_cnt_w = clog2_cnt(DEPTH);

  `REG_PARAM_CHECK(g_chk_width, WIDTH >= 1, "reg_pipeline: WIDTH must be >= 1")
  `REG_PARAM_CHECK(g_chk_depth, DEPTH >= 1, "reg_pipeline: DEPTH must be >= 1")

  logic [DEPTH-1:0]   w_v;
  logic [DEPTH-1:0]   w_adv;
  logic [DEPTH-1:0]   w_load;
  logic [WIDTH-1:0]   w_d [DEPTH];
  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [c_cnt_w-1:0] r_count;

  // The ready chain adv[k] = ~v[k+1] | adv[k+1] unrolls to "out_ready, or
  // any stage above k is empty"; computing it from w_v alone keeps the
  // chain free of self-referencing combinational feedback.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_adv[k] = bus.out_ready;
      for (int j = k + 1; j < DEPTH; j++) begin
        if (!w_v[j]) begin
          w_adv[k] = 1'b1;
        end
      end
    end
  end

  assign w_load     = ~w_v | w_adv;
  assign w_in_ready = w_load[0] & ~bus.flush & ~reset;
  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = w_v[DEPTH-1] & bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.flush),
        .up_valid (bus.in_valid),
        .up_data  (bus.in_data),
        .load     (w_load[k]),
        .v        (w_v[k]),
        .d        (w_d[k])
      );
    end else begin : g_body
      pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.flush),
        .up_valid (w_v[k-1]),
        .up_data  (w_d[k-1]),
        .load     (w_load[k]),
        .v        (w_v[k]),
        .d        (w_d[k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_cnt_w'(w_in_xfer) - c_cnt_w'(w_out_xfer);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_v[DEPTH-1];
  assign bus.out_data  = w_d[DEPTH-1];
  assign bus.count     = r_count;

endmodule

`default_nettype wire
